// File: rtl/fetch_controller.sv
// ============================================================================
//  Module   : fetch_controller
//  Purpose  : Instruction-fetch sequencer. Owns the program counter and picks
//             each cycle between advance-by-4, stall hold, or MEM redirect.
//             Raises pipeline flush pulses on redirect and, on fetching the
//             halt word, drains the pipeline before declaring halt.
//  Ports    : CLK, RESET (async, active-low)
//             stall_req, PCSrc, PC_next_jumpOrBranch[31:0], instruction[31:0]
//             currentPC[31:0], PCPlus4[31:0], fetch_en, instr_valid,
//             flush_IF_ID, flush_ID_EX, flush_EX_MEM, misalign_err, halted,
//             cycle_count[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        stall_req,
   input  logic        PCSrc,
   input  logic [31:0] PC_next_jumpOrBranch,
   input  logic [31:0] instruction,
   output logic [31:0] currentPC,
   output logic [31:0] PCPlus4,
   output logic        fetch_en,
   output logic        instr_valid,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        flush_EX_MEM,
   output logic        misalign_err,
   output logic        halted,
   output logic [31:0] cycle_count
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [3:0]  drain_cnt_q, drain_cnt_d;
   logic        misalign_q, misalign_d;
   logic [31:0] cycle_q;
   logic        flush_w;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_RUN;
         pc_q        <= RESET_PC;
         drain_cnt_q <= 4'd0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drain_cnt_q <= drain_cnt_d;
         misalign_q  <= misalign_d;
      end
   end

   // Cycle counter runs until halt and saturates rather than wrapping.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cycle_q <= 32'd0;
      end else if (state_q != S_HALTED && cycle_q != 32'hFFFF_FFFF) begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drain_cnt_d = drain_cnt_q;
      misalign_d  = misalign_q;
      fetch_en    = 1'b0;
      instr_valid = 1'b0;
      flush_w     = 1'b0;

      case (state_q)
         S_RUN, S_DRAIN: begin
            if (PCSrc) begin
               // Redirect wins over everything; in DRAIN it also means the
               // halt word was on the wrong path, so resume fetching.
               pc_d        = {PC_next_jumpOrBranch[31:2], 2'b00};
               flush_w     = 1'b1;
               fetch_en    = 1'b1;
               state_d     = S_RUN;
               drain_cnt_d = 4'd0;
               if (PC_next_jumpOrBranch[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end
            end else if (state_q == S_DRAIN) begin
               // stall_req is irrelevant while draining.
               if (drain_cnt_q == 4'd0) begin
                  state_d = S_HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - 4'd1;
               end
            end else if (stall_req) begin
               // Hold PC; halt word is deliberately not examined here.
            end else if (instruction == HALT_WORD) begin
               // Let the halt word itself enter ID, then stop fetching.
               fetch_en    = 1'b1;
               instr_valid = 1'b1;
               state_d     = S_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end else begin
               fetch_en    = 1'b1;
               instr_valid = 1'b1;
               pc_d        = pc_q + 32'd4;
            end
         end
         default: begin
            // HALTED: frozen until reset.
         end
      endcase
   end

   assign currentPC    = pc_q;
   assign PCPlus4      = pc_q + 32'd4;
   assign flush_IF_ID  = flush_w;
   assign flush_ID_EX  = flush_w;
   assign flush_EX_MEM = flush_w;
   assign misalign_err = misalign_q;
   assign halted       = (state_q == S_HALTED);
   assign cycle_count  = cycle_q;

endmodule

`default_nettype wire
